// File: rtl/linear_sched.sv
// linear_sched: round-robin scheduler sharing one linear engine (matrix multiply
// plus bias) between NUM_REQ requesters. It arbitrates, holds the operand-mux
// select, pulses the engine start, waits for the rising edge of lin_done and
// returns a one-cycle ack to the owner.
// Optional build macro: LINEAR_SCHED_TIMEOUT_EN enables a watchdog that aborts
// a job stuck in WAIT after TIMEOUT_CYCLES cycles and flags it on err.
module linear_sched #(
    parameter int NUM_REQ        = 3,
    parameter int SEL_W          = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               lin_start,
    input  logic               lin_done,
    output logic [NUM_REQ-1:0] ack,
    output logic               err,
    output logic               busy,
    output logic [15:0]        job_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_d;

    logic [SEL_W-1:0]   rr_ptr;
    logic [SEL_W-1:0]   rr_ptr_d;
    logic               done_q;
    logic               done_edge;
    logic               timeout;

    logic               win_found;
    logic [SEL_W-1:0]   win_idx;
    logic [SEL_W-1:0]   cand;

    logic [NUM_REQ-1:0] grant_d;
    logic [SEL_W-1:0]   sel_d;
    logic               lin_start_d;
    logic [NUM_REQ-1:0] ack_d;
    logic               err_d;
    logic               busy_d;
    logic [15:0]        job_cnt_d;

    // A done level left over from the previous job must not complete the next one.
    assign done_edge = lin_done && !done_q;

    // Round-robin search: first requester at or after rr_ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = SEL_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef LINEAR_SCHED_TIMEOUT_EN
    logic [31:0] wait_cnt;

    // Watchdog counter: restarts on every entry to WAIT, counts cycles spent there.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == LAUNCH) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 32'd1;
        end
    end

    assign timeout = (state == WAIT) && (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog a job waits for the engine forever; err never fires.
    assign timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic: arbitrate, launch, wait for completion, respond.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (done_edge || timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, so every output changes on a clock edge.
    always_comb begin
        grant_d     = grant;
        sel_d       = sel;
        lin_start_d = 1'b0;
        ack_d       = '0;
        err_d       = 1'b0;
        job_cnt_d   = job_cnt;
        rr_ptr_d    = rr_ptr;
        busy_d      = (state_d != IDLE);
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                    sel_d       = win_idx;
                    lin_start_d = 1'b1;
                end
            end
            LAUNCH: begin
            end
            WAIT: begin
                if (done_edge || timeout) begin
                    ack_d     = grant;
                    err_d     = timeout && !done_edge;
                    job_cnt_d = job_cnt + 16'd1;
                    rr_ptr_d  = (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + SEL_W'(1);
                end
            end
            RESP: begin
                grant_d = '0;
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    // Output, pointer and done-history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant     <= '0;
            sel       <= '0;
            lin_start <= 1'b0;
            ack       <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            job_cnt   <= '0;
            rr_ptr    <= '0;
            done_q    <= 1'b0;
        end else begin
            grant     <= grant_d;
            sel       <= sel_d;
            lin_start <= lin_start_d;
            ack       <= ack_d;
            err       <= err_d;
            busy      <= busy_d;
            job_cnt   <= job_cnt_d;
            rr_ptr    <= rr_ptr_d;
            done_q    <= lin_done;
        end
    end

endmodule
